// File: rtl/scan_sequencer_if.sv
// Handshake/bus bundle for scan_sequencer.
//   master: start/stop requests, mode, dwell, ch_mask out; selection and status in
//   slave : the sequencer side (requests in; sel, sel_valid, busy, ch_tick, done, err out)
interface scan_sequencer_if #(
    parameter int unsigned DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic               mode;
    logic [DWELL_W-1:0] dwell;
    logic [7:0]         ch_mask;
    logic [2:0]         sel;
    logic               sel_valid;
    logic               busy;
    logic               ch_tick;
    logic               done;
    logic               err;

    modport master (
        output start, stop, mode, dwell, ch_mask,
        input  sel, sel_valid, busy, ch_tick, done, err
    );

    modport slave (
        input  start, stop, mode, dwell, ch_mask,
        output sel, sel_valid, busy, ch_tick, done, err
    );
endinterface

// File: rtl/scan_sequencer.sv
// Channel scan sequencer: steps a 3-bit decoder select through the enabled
// channels of an 8-bit mask, holding each for a programmable dwell.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : scan_sequencer_if.slave (start/stop/mode/dwell/ch_mask in;
//          sel/sel_valid/busy/ch_tick/done/err out, all registered)
module scan_sequencer #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    scan_sequencer_if.slave   bus
);
    localparam int unsigned CH_N  = 8;
    localparam int unsigned SEL_W = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               sel_valid_q, sel_valid_d;
    logic               busy_q, busy_d;
    logic               ch_tick_q, ch_tick_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               mode_q, mode_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [CH_N-1:0]    mask_q, mask_d;

    logic               nxt_found;
    logic [SEL_W-1:0]   nxt_idx;

    // Lowest set bit of a channel mask (0 when the mask is empty).
    function automatic logic [SEL_W-1:0] lowest_idx(input logic [CH_N-1:0] m);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = CH_N - 1; i >= 0; i--) begin
            if (m[i]) idx = SEL_W'(i);
        end
        return idx;
    endfunction

    // Counter reload value: remaining cycles after the first, dwell 0 acts as 1.
    function automatic logic [DWELL_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
        return (d == '0) ? '0 : d - DWELL_W'(1);
    endfunction

    // Next enabled index strictly above the current selection.
    always_comb begin
        nxt_found = 1'b0;
        nxt_idx   = '0;
        for (int i = CH_N - 1; i >= 0; i--) begin
            if (mask_q[i] && (SEL_W'(i) > sel_q)) begin
                nxt_found = 1'b1;
                nxt_idx   = SEL_W'(i);
            end
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        sel_valid_d = sel_valid_q;
        busy_d      = busy_q;
        ch_tick_d   = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        dwell_d     = dwell_q;
        mask_d      = mask_q;

        unique case (state_q)
            ST_IDLE: begin
                // stop beats start; an empty mask rejects the start
                if (bus.start && !bus.stop) begin
                    if (bus.ch_mask != '0) begin
                        state_d     = ST_SCAN;
                        mode_d      = bus.mode;
                        dwell_d     = bus.dwell;
                        mask_d      = bus.ch_mask;
                        sel_d       = lowest_idx(bus.ch_mask);
                        sel_valid_d = 1'b1;
                        busy_d      = 1'b1;
                        ch_tick_d   = 1'b1;
                        cnt_d       = dwell_load(bus.dwell);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                if (bus.stop) begin
                    state_d     = ST_IDLE;
                    sel_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    cnt_d       = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (nxt_found) begin
                    sel_d     = nxt_idx;
                    ch_tick_d = 1'b1;
                    cnt_d     = dwell_load(dwell_q);
                end else if (mode_q) begin
                    sel_d     = lowest_idx(mask_q);
                    ch_tick_d = 1'b1;
                    cnt_d     = dwell_load(dwell_q);
                end else begin
                    state_d     = ST_IDLE;
                    sel_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ch_tick_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            dwell_q     <= '0;
            mask_q      <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
            busy_q      <= busy_d;
            ch_tick_q   <= ch_tick_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            dwell_q     <= dwell_d;
            mask_q      <= mask_d;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.sel_valid = sel_valid_q;
    assign bus.busy      = busy_q;
    assign bus.ch_tick   = ch_tick_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed self-checking bench for scan_sequencer.
module tb_scan_sequencer;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    scan_sequencer_if #(.DWELL_W(8)) bus_if ();

    scan_sequencer #(.DWELL_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input int sel, input int valid,
                              input int busy, input int tick, input int done, input int err);
        check({tag, ".sel"},       int'(bus_if.sel),       sel);
        check({tag, ".sel_valid"}, int'(bus_if.sel_valid), valid);
        check({tag, ".busy"},      int'(bus_if.busy),      busy);
        check({tag, ".ch_tick"},   int'(bus_if.ch_tick),   tick);
        check({tag, ".done"},      int'(bus_if.done),      done);
        check({tag, ".err"},       int'(bus_if.err),       err);
    endtask

    task automatic launch(input logic m, input logic [7:0] d, input logic [7:0] msk);
        bus_if.mode    = m;
        bus_if.dwell   = d;
        bus_if.ch_mask = msk;
        bus_if.start   = 1'b1;
        step();
        bus_if.start   = 1'b0;
    endtask

    task automatic abort();
        bus_if.stop = 1'b1;
        step();
        bus_if.stop = 1'b0;
    endtask

    initial begin
        int exp_sel [3];
        int ticks;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus_if.start   = 1'b0;
        bus_if.stop    = 1'b0;
        bus_if.mode    = 1'b0;
        bus_if.dwell   = 8'd0;
        bus_if.ch_mask = 8'd0;
        step();
        step();
        rst = 1'b0;
        expect_out("reset", 0, 0, 0, 0, 0, 0);

        // Single pass over all channels, dwell 2
        launch(1'b0, 8'd2, 8'hFF);
        for (int k = 0; k < 16; k++) begin
            expect_out($sformatf("ff_k%0d", k), k / 2, 1, 1, (k % 2 == 0) ? 1 : 0, 0, 0);
            step();
        end
        expect_out("ff_done", 7, 0, 0, 0, 1, 0);
        step();
        expect_out("ff_after", 7, 0, 0, 0, 0, 0);

        // Dwell 0 acts as 1, sparse mask skips disabled indices
        exp_sel = '{2, 5, 7};
        launch(1'b0, 8'd0, 8'b1010_0100);
        for (int k = 0; k < 3; k++) begin
            expect_out($sformatf("sparse_k%0d", k), exp_sel[k], 1, 1, 1, 0, 0);
            step();
        end
        expect_out("sparse_done", 7, 0, 0, 0, 1, 0);
        step();

        // Continuous wrap between 0 and 7, then stop
        launch(1'b1, 8'd1, 8'h81);
        for (int k = 0; k < 6; k++) begin
            expect_out($sformatf("wrap_k%0d", k), (k % 2 == 0) ? 0 : 7, 1, 1, 1, 0, 0);
            if (k < 5) step();
        end
        abort();
        expect_out("wrap_stop", 7, 0, 0, 0, 0, 0);
        step();
        expect_out("wrap_stop2", 7, 0, 0, 0, 0, 0);

        // Single-bit mask in wrap mode reselects the same index
        launch(1'b1, 8'd2, 8'h10);
        for (int k = 0; k < 6; k++) begin
            expect_out($sformatf("one_k%0d", k), 4, 1, 1, (k % 2 == 0) ? 1 : 0, 0, 0);
            if (k < 5) step();
        end
        abort();
        expect_out("one_stop", 4, 0, 0, 0, 0, 0);

        // Empty mask rejected with err; start+stop together does nothing
        launch(1'b0, 8'd1, 8'h00);
        expect_out("err_pulse", 4, 0, 0, 0, 0, 1);
        step();
        expect_out("err_clear", 4, 0, 0, 0, 0, 0);
        bus_if.ch_mask = 8'hFF;
        bus_if.start   = 1'b1;
        bus_if.stop    = 1'b1;
        step();
        bus_if.start   = 1'b0;
        bus_if.stop    = 1'b0;
        expect_out("startstop", 4, 0, 0, 0, 0, 0);
        step();
        expect_out("startstop2", 4, 0, 0, 0, 0, 0);

        // Input changes during SCAN are ignored
        launch(1'b0, 8'd3, 8'h0C);
        bus_if.mode    = 1'b1;
        bus_if.dwell   = 8'd1;
        bus_if.ch_mask = 8'h01;
        for (int k = 0; k < 6; k++) begin
            expect_out($sformatf("shadow_k%0d", k), (k < 3) ? 2 : 3, 1, 1,
                       (k == 0 || k == 3) ? 1 : 0, 0, 0);
            step();
        end
        expect_out("shadow_done", 3, 0, 0, 0, 1, 0);
        step();

        // Reset mid-dwell aborts with no done
        launch(1'b0, 8'd3, 8'h0C);
        step();
        expect_out("mid_dwell", 2, 1, 1, 0, 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        expect_out("mid_rst", 0, 0, 0, 0, 0, 0);
        step();
        expect_out("mid_rst2", 0, 0, 0, 0, 0, 0);

        // Reset beats start; start honoured on first edge with rst low
        rst = 1'b1;
        bus_if.start = 1'b1;
        step();
        expect_out("rst_prio", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        step();
        bus_if.start = 1'b0;
        expect_out("rst_release", 2, 1, 1, 1, 0, 0);
        abort();
        expect_out("rst_release_stop", 2, 0, 0, 0, 0, 0);

        // Start held across a pass: restart one cycle after done
        bus_if.mode    = 1'b0;
        bus_if.dwell   = 8'd1;
        bus_if.ch_mask = 8'h06;
        bus_if.start   = 1'b1;
        step();
        expect_out("held_p1a", 1, 1, 1, 1, 0, 0);
        step();
        expect_out("held_p1b", 2, 1, 1, 1, 0, 0);
        step();
        expect_out("held_done", 2, 0, 0, 0, 1, 0);
        step();
        expect_out("held_p2a", 1, 1, 1, 1, 0, 0);
        bus_if.start = 1'b0;
        abort();
        expect_out("held_stop", 1, 0, 0, 0, 0, 0);

        // Maximum dwell with no counter overflow
        launch(1'b0, 8'd255, 8'h01);
        ticks = 0;
        for (int k = 0; k < 255; k++) begin
            if (bus_if.ch_tick) ticks++;
            if (k == 254) check("maxdw_busy", int'(bus_if.busy), 1);
            step();
        end
        check("maxdw_ticks", ticks, 1);
        expect_out("maxdw_done", 0, 0, 0, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 Parameter: DWELL_W, default 8, width of the per-channel dwell count.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request to begin a scan; sampled at a rising edge.
REQ-005 Port: stop  input  1  request to abort the active scan.
REQ-006 Port: mode  input  1  0 = single pass, 1 = continuous wrap.
REQ-007 Port: dwell  input  DWELL_W  cycles each channel stays selected; 0 is treated as 1.
REQ-008 Port: ch_mask  input  8  channel enable, bit i enables index i.
REQ-009 Port: sel  output  3  current channel index, drives the 3-to-8 decoder input.
REQ-010 Port: sel_valid  output  1  high while sel is a live selection.
REQ-011 Port: busy  output  1  high while the FSM is in SCAN.
REQ-012 Port: ch_tick  output  1  one-cycle pulse on the first cycle of each channel selection.
REQ-013 Port: done  output  1  one-cycle pulse when a single pass completes normally.
REQ-014 Port: err  output  1  one-cycle pulse when start is rejected for an all-zero mask.

Function
REQ-015 FSM states: IDLE, SCAN; all outputs are registered.
REQ-016 In IDLE, start=1, stop=0 and ch_mask!=0 at edge T: mode, dwell and ch_mask latch into shadow registers; SCAN is entered at T+1.
REQ-017 At T+1, sel = lowest set bit of shadow mask, sel_valid=1, busy=1, ch_tick=1.
REQ-018 Each channel stays selected for D = max(dwell,1) cycles, counted by a down-counter loaded on selection.
REQ-019 On dwell expiry, sel advances to the next higher enabled index, with ch_tick=1 on its first cycle.
REQ-020 Disabled indices are skipped, with zero idle cycles between channels.
REQ-021 End of pass (no higher enabled index), mode=1: sel wraps to the lowest enabled index; no done pulse.
REQ-022 End of pass, mode=0: the next cycle enters IDLE with sel_valid=0, busy=0 and done=1 for one cycle.
REQ-023 sel holds its last value in IDLE.
REQ-024 In IDLE, start=1 with ch_mask==0: the start is rejected, err=1 for one cycle, and the FSM stays in IDLE.
REQ-025 In IDLE, start and stop high in the same cycle: stop wins, and start is ignored with no err.
REQ-026 stop=1 in SCAN: the next cycle enters IDLE with sel_valid=0, busy=0, done=0, ch_tick=0, and the current dwell is abandoned.
REQ-027 start=1 in SCAN is ignored.
REQ-028 Input changes to mode, dwell or ch_mask during SCAN have no effect until the next accepted start.
REQ-029 A single-bit shadow mask in mode=1 reselects the same index every D cycles, with ch_tick each time.
REQ-030 A dwell counter of DWELL_W bits supports a maximum dwell of 2^DWELL_W-1 with no overflow.
REQ-031 done, err and ch_tick are never high for more than one consecutive cycle, except ch_tick when D=1.

Reset
REQ-032 rst=1 at an edge forces the following on the next cycle, regardless of state: IDLE, sel=0, sel_valid=0, busy=0, ch_tick=0, done=0, err=0, dwell counter=0, shadow registers=0.
REQ-033 Reset asserted during SCAN aborts without a done pulse.
REQ-034 Reset has priority over start and stop in the same cycle.
REQ-035 start is first honoured at the first edge with rst=0.

Verification
REQ-036 Scenario: mode=0, dwell=2, ch_mask=8'hFF, start at T -> sel=0..7 each held 2 cycles from T+1, ch_tick at T+1,T+3,...,T+15, done=1 at T+17, busy=0 at T+17.
REQ-037 Scenario: mode=0, dwell=0, ch_mask=8'b1010_0100 -> sel=2,5,7 on consecutive cycles, ch_tick each cycle, done on the 4th cycle after start.
REQ-038 Scenario: mode=1, dwell=1, ch_mask=8'h81 -> sel alternates 0,7,0,7...; stop asserted -> sel_valid=0 and busy=0 the next cycle, no done.
REQ-039 Scenario: start with ch_mask=0 -> err=1 for one cycle, busy stays 0; start and stop together in IDLE -> no activity.
REQ-040 Scenario: dwell=3 scan in progress, rst pulsed mid-dwell -> all outputs at reset values the next cycle, no done; ch_mask and dwell changed mid-scan -> no effect on the sel sequence.
REQ-041 Scenario: start held high across a whole mode=0 pass -> the second pass begins exactly one cycle after the done pulse, and start during SCAN is ignored.
